// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Turns byte/halfword/word load and store requests into accesses on a
// word-wide RAM. The RAM is big-endian: byte offset 0 sits in bits 31:24.
// Sub-word stores use a read-modify-write sequence. Misaligned halfword and
// word accesses are answered with a fault and never touch the RAM.
//
// Ports
//   clock            single clock, all state changes on the rising edge
//   reset_n          asynchronous active-low reset
//   req_valid        request present
//   req_ready        unit can accept a request (only while idle)
//   req_op           0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW
//   req_addr         byte address
//   req_wdata        store data, right-justified for SB/SH
//   resp_valid       response present
//   resp_ready       consumer takes the response
//   resp_rdata       extended load data; 0 for stores and faults
//   resp_misaligned  alignment fault flag
//   ram_address      RAM word index (byte address / 4)
//   ram_writedata    word written to the RAM
//   ram_load         RAM write enable
//   ram_out          RAM read data, combinational from ram_address
// ---------------------------------------------------------------------------
module mem_access_unit #(
   parameter int RAM_AW = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_misaligned,
   output logic [RAM_AW-1:0] ram_address,
   output logic [31:0]       ram_writedata,
   output logic              ram_load,
   input  logic [31:0]       ram_out
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] WRITE  = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam logic [2:0] OP_LB  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LW  = 3'd2;
   localparam logic [2:0] OP_LBU = 3'd3;
   localparam logic [2:0] OP_LHU = 3'd4;
   localparam logic [2:0] OP_SB  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SW  = 3'd7;

   logic [1:0]  state;
   logic [2:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        misaligned_q;
   logic [31:0] merged_q;

   logic        req_misaligned;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_value;
   logic [31:0] merged_value;
   logic        store_word;

   // Alignment check is done on the live request so a faulting access can
   // go straight to the response state at the acceptance edge.
   always_comb begin
      req_misaligned = 1'b0;
      case (req_op)
         OP_LH, OP_LHU, OP_SH: req_misaligned = req_addr[0];
         OP_LW, OP_SW:         req_misaligned = |req_addr[1:0];
         default:              req_misaligned = 1'b0;
      endcase
   end

   // Big-endian lane selection: lower byte offsets live in higher bits.
   always_comb begin
      byte_lane = ram_out[31:24];
      case (addr_q[1:0])
         2'd0: byte_lane = ram_out[31:24];
         2'd1: byte_lane = ram_out[23:16];
         2'd2: byte_lane = ram_out[15:8];
         2'd3: byte_lane = ram_out[7:0];
         default: byte_lane = ram_out[31:24];
      endcase
      half_lane = addr_q[1] ? ram_out[15:0] : ram_out[31:16];
   end

   always_comb begin
      load_value = 32'd0;
      case (op_q)
         OP_LB:   load_value = {{24{byte_lane[7]}}, byte_lane};
         OP_LH:   load_value = {{16{half_lane[15]}}, half_lane};
         OP_LW:   load_value = ram_out;
         OP_LBU:  load_value = {24'd0, byte_lane};
         OP_LHU:  load_value = {16'd0, half_lane};
         default: load_value = 32'd0;
      endcase
   end

   // Read-modify-write merge for sub-word stores: the current RAM word with
   // only the addressed lane replaced by the store data.
   always_comb begin
      merged_value = ram_out;
      if (op_q == OP_SB) begin
         case (addr_q[1:0])
            2'd0: merged_value[31:24] = wdata_q[7:0];
            2'd1: merged_value[23:16] = wdata_q[7:0];
            2'd2: merged_value[15:8]  = wdata_q[7:0];
            2'd3: merged_value[7:0]   = wdata_q[7:0];
            default: merged_value = ram_out;
         endcase
      end else if (op_q == OP_SH) begin
         if (addr_q[1]) begin
            merged_value[15:0] = wdata_q[15:0];
         end else begin
            merged_value[31:16] = wdata_q[15:0];
         end
      end
   end

   // Main sequencer. A reset clears the state to IDLE immediately, which
   // also drops ram_load combinationally, so an aborted store never lands.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         op_q         <= 3'd0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         rdata_q      <= 32'd0;
         misaligned_q <= 1'b0;
         merged_q     <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q         <= req_op;
                  addr_q       <= req_addr;
                  wdata_q      <= req_wdata;
                  rdata_q      <= 32'd0;
                  misaligned_q <= req_misaligned;
                  state        <= req_misaligned ? RESP : ACCESS;
               end
            end
            ACCESS: begin
               if (op_q == OP_SB || op_q == OP_SH) begin
                  merged_q <= merged_value;
                  state    <= WRITE;
               end else begin
                  if (op_q != OP_SW) begin
                     rdata_q <= load_value;
                  end
                  state <= RESP;
               end
            end
            WRITE: begin
               state <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign store_word = (state == ACCESS) && (op_q == OP_SW);

   assign req_ready       = (state == IDLE);
   assign resp_valid      = (state == RESP);
   assign resp_rdata      = rdata_q;
   assign resp_misaligned = misaligned_q;
   assign ram_load        = (state == WRITE) || store_word;

   always_comb begin
      ram_writedata = 32'd0;
      if (state == WRITE) begin
         ram_writedata = merged_q;
      end else if (store_word) begin
         ram_writedata = wdata_q;
      end
   end

   // Word index is the byte address without its two offset bits, fitted to
   // the RAM address width.
   generate
      if (RAM_AW > 30) begin : g_addr_extend
         assign ram_address = {{(RAM_AW-30){1'b0}}, addr_q[31:2]};
      end else if (RAM_AW == 30) begin : g_addr_exact
         assign ram_address = addr_q[31:2];
      end else begin : g_addr_truncate
         assign ram_address = addr_q[RAM_AW+1:2];
      end
   endgenerate

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed bench for mem_access_unit with a 16-word RAM model attached.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

   logic        clock;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_misaligned;
   logic [31:0] ram_address;
   logic [31:0] ram_writedata;
   logic        ram_load;
   logic [31:0] ram_out;

   logic [31:0] mem [0:15];

   int          vectors;
   int          miscompares;
   int          load_cnt;
   longint      acc_time;
   longint      last_load_time;
   logic [31:0] last_waddr;
   logic [31:0] last_wdata;

   int          lat;
   logic [31:0] rd;
   logic        mis;

   mem_access_unit #(.RAM_AW(32)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_op          (req_op),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_rdata      (resp_rdata),
      .resp_misaligned (resp_misaligned),
      .ram_address     (ram_address),
      .ram_writedata   (ram_writedata),
      .ram_load        (ram_load),
      .ram_out         (ram_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // RAM model: combinational read, write on the rising edge.
   assign ram_out = mem[ram_address[3:0]];
   always @(posedge clock) begin
      if (ram_load === 1'b1) mem[ram_address[3:0]] <= ram_writedata;
   end

   // Write-enable monitor, sampled mid-cycle.
   always @(negedge clock) begin
      if (ram_load === 1'b1) begin
         load_cnt       = load_cnt + 1;
         last_load_time = $time;
         last_waddr     = ram_address;
         last_wdata     = ram_writedata;
      end
   end

   // Issue one request, wait (bounded) for the response and take it.
   // lat counts rising edges after acceptance before resp_valid is seen;
   // 99 marks a timeout.
   task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata);
      @(posedge clock); #2;
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
      load_cnt = 0;
      @(posedge clock);
      acc_time = $time;
      #2;
      req_valid = 1'b0;
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 10) begin
         @(posedge clock); #2;
         lat = lat + 1;
      end
      if (resp_valid !== 1'b1) lat = 99;
      rd  = resp_rdata;
      mis = resp_misaligned;
      resp_ready = 1'b1;
      @(posedge clock); #2;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      vectors += 7;
      if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_req_ready: got %b, expected 1", req_ready); end
      if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_resp_valid: got %b, expected 0", resp_valid); end
      if (resp_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h, expected 0", resp_rdata); end
      if (resp_misaligned !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_misaligned: got %b, expected 0", resp_misaligned); end
      if (ram_address !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_ram_address: got %h, expected 0", ram_address); end
      if (ram_writedata !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_ram_writedata: got %h, expected 0", ram_writedata); end
      if (ram_load !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ram_load: got %b, expected 0", ram_load); end
      @(posedge clock); #2;
      reset_n = 1'b1;
   endtask

   // Word 4 = 0x8899AABB; big-endian lane extraction and extension.
   task automatic test_loads();
      logic [2:0]  ops  [6] = '{3'd0, 3'd3, 3'd4, 3'd1, 3'd0, 3'd2};
      logic [31:0] adrs [6] = '{32'h11, 32'h11, 32'h12, 32'h10, 32'h13, 32'h10};
      logic [31:0] exps [6] = '{32'hFFFFFF99, 32'h00000099, 32'h0000AABB,
                                32'hFFFF8899, 32'hFFFFFFBB, 32'h8899AABB};
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(ops[i], adrs[i], 32'hFFFFFFFF);
         vectors += 4;
         if (rd !== exps[i]) begin miscompares++; $display("[TB] FAIL load%0d_rdata: got %h, expected %h", i, rd, exps[i]); end
         if (mis !== 1'b0) begin miscompares++; $display("[TB] FAIL load%0d_misaligned: got %b, expected 0", i, mis); end
         if (lat != 1) begin miscompares++; $display("[TB] FAIL load%0d_latency: got %0d, expected 1", i, lat); end
         if (load_cnt != 0) begin miscompares++; $display("[TB] FAIL load%0d_ram_load: got %0d cycles, expected 0", i, load_cnt); end
      end
   endtask

   task automatic test_store_half();
      apply_stimulus(3'd6, 32'h12, 32'h00001234);
      vectors += 6;
      if (lat != 2) begin miscompares++; $display("[TB] FAIL sh_latency: got %0d, expected 2", lat); end
      if (rd !== 32'd0) begin miscompares++; $display("[TB] FAIL sh_rdata: got %h, expected 0", rd); end
      if (load_cnt != 1) begin miscompares++; $display("[TB] FAIL sh_load_cycles: got %0d, expected 1", load_cnt); end
      if (last_load_time - acc_time != 15) begin miscompares++; $display("[TB] FAIL sh_load_in_write: got offset %0d, expected 15", last_load_time - acc_time); end
      if (last_waddr !== 32'd4) begin miscompares++; $display("[TB] FAIL sh_ram_address: got %h, expected 4", last_waddr); end
      if (last_wdata !== 32'h88991234) begin miscompares++; $display("[TB] FAIL sh_writedata: got %h, expected 88991234", last_wdata); end
      apply_stimulus(3'd2, 32'h10, 32'd0);
      vectors++;
      if (rd !== 32'h88991234) begin miscompares++; $display("[TB] FAIL sh_readback: got %h, expected 88991234", rd); end
   endtask

   task automatic test_store_word();
      apply_stimulus(3'd7, 32'h10, 32'hDEADBEEF);
      vectors += 6;
      if (lat != 1) begin miscompares++; $display("[TB] FAIL sw_latency: got %0d, expected 1", lat); end
      if (rd !== 32'd0) begin miscompares++; $display("[TB] FAIL sw_rdata: got %h, expected 0", rd); end
      if (load_cnt != 1) begin miscompares++; $display("[TB] FAIL sw_load_cycles: got %0d, expected 1", load_cnt); end
      if (last_load_time - acc_time != 5) begin miscompares++; $display("[TB] FAIL sw_load_in_access: got offset %0d, expected 5", last_load_time - acc_time); end
      if (last_waddr !== 32'd4) begin miscompares++; $display("[TB] FAIL sw_ram_address: got %h, expected 4", last_waddr); end
      if (last_wdata !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL sw_writedata: got %h, expected deadbeef", last_wdata); end
      apply_stimulus(3'd2, 32'h10, 32'd0);
      vectors++;
      if (rd !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL sw_readback: got %h, expected deadbeef", rd); end
   endtask

   task automatic test_misaligned();
      logic [2:0]  ops  [2] = '{3'd2, 3'd6};
      logic [31:0] adrs [2] = '{32'h13, 32'h11};
      for (int i = 0; i < 2; i++) begin
         apply_stimulus(ops[i], adrs[i], 32'h0000FFFF);
         vectors += 4;
         if (mis !== 1'b1) begin miscompares++; $display("[TB] FAIL misal%0d_flag: got %b, expected 1", i, mis); end
         if (rd !== 32'd0) begin miscompares++; $display("[TB] FAIL misal%0d_rdata: got %h, expected 0", i, rd); end
         if (lat != 0) begin miscompares++; $display("[TB] FAIL misal%0d_latency: got %0d, expected 0", i, lat); end
         if (load_cnt != 0) begin miscompares++; $display("[TB] FAIL misal%0d_ram_load: got %0d cycles, expected 0", i, load_cnt); end
      end
      apply_stimulus(3'd2, 32'h10, 32'd0);
      vectors += 2;
      if (rd !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL misal_ram_unchanged: got %h, expected deadbeef", rd); end
      if (mis !== 1'b0) begin miscompares++; $display("[TB] FAIL misal_flag_cleared: got %b, expected 0", mis); end
   endtask

   task automatic test_reset_in_write();
      @(posedge clock); #2;
      req_valid = 1'b1; req_op = 3'd5; req_addr = 32'h10; req_wdata = 32'h00000055;
      load_cnt = 0;
      @(posedge clock); #2;
      req_valid = 1'b0;
      @(posedge clock); #2;
      vectors += 2;
      if (ram_load !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_write_enable: got %b, expected 1", ram_load); end
      if (ram_writedata !== 32'h55ADBEEF) begin miscompares++; $display("[TB] FAIL sb_merged: got %h, expected 55adbeef", ram_writedata); end
      reset_n = 1'b0;
      #1;
      vectors += 5;
      if (ram_load !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_ram_load: got %b, expected 0", ram_load); end
      if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_resp_valid: got %b, expected 0", resp_valid); end
      if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_req_ready: got %b, expected 1", req_ready); end
      if (ram_address !== 32'd0) begin miscompares++; $display("[TB] FAIL abort_ram_address: got %h, expected 0", ram_address); end
      if (ram_writedata !== 32'd0) begin miscompares++; $display("[TB] FAIL abort_writedata: got %h, expected 0", ram_writedata); end
      @(posedge clock); #2;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #2;
         vectors++;
         if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_no_resp%0d: got %b, expected 0", i, resp_valid); end
      end
      vectors++;
      if (load_cnt != 0) begin miscompares++; $display("[TB] FAIL abort_no_write: got %0d cycles, expected 0", load_cnt); end
      apply_stimulus(3'd2, 32'h10, 32'd0);
      vectors++;
      if (rd !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL abort_word_unchanged: got %h, expected deadbeef", rd); end
   endtask

   task automatic test_resp_stall();
      int wait_cnt;
      @(posedge clock); #2;
      req_valid = 1'b1; req_op = 3'd0; req_addr = 32'h10; req_wdata = 32'd0;
      @(posedge clock); #2;
      req_valid = 1'b0;
      wait_cnt = 0;
      while (resp_valid !== 1'b1 && wait_cnt < 10) begin
         @(posedge clock); #2;
         wait_cnt++;
      end
      vectors++;
      if (wait_cnt != 1) begin miscompares++; $display("[TB] FAIL stall_latency: got %0d, expected 1", wait_cnt); end
      // A competing misaligned request must be ignored while stalled.
      req_valid = 1'b1; req_op = 3'd2; req_addr = 32'h13;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #2;
         vectors += 4;
         if (resp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall%0d_valid: got %b, expected 1", i, resp_valid); end
         if (resp_rdata !== 32'hFFFFFFDE) begin miscompares++; $display("[TB] FAIL stall%0d_rdata: got %h, expected ffffffde", i, resp_rdata); end
         if (resp_misaligned !== 1'b0) begin miscompares++; $display("[TB] FAIL stall%0d_misaligned: got %b, expected 0", i, resp_misaligned); end
         if (req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL stall%0d_req_ready: got %b, expected 0", i, req_ready); end
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clock); #2;
      resp_ready = 1'b0;
      vectors += 2;
      if (resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_done_valid: got %b, expected 0", resp_valid); end
      if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_done_ready: got %b, expected 1", req_ready); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      load_cnt    = 0;
      acc_time    = 0;
      last_load_time = 0;
      last_waddr  = 32'd0;
      last_wdata  = 32'd0;
      reset_n     = 1'b0;
      req_valid   = 1'b0;
      req_op      = 3'd0;
      req_addr    = 32'd0;
      req_wdata   = 32'd0;
      resp_ready  = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 32'd0;
      mem[4] = 32'h8899AABB;

      test_reset();
      test_loads();
      test_store_half();
      test_store_word();
      test_misaligned();
      test_reset_in_write();
      test_resp_stall();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter: RAM_AW, 32, width of ram_address (word index).
REQ-002 SHALL have port: clock  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  in  1  request present.
REQ-005 SHALL have port: req_ready  out  1  unit can accept a request.
REQ-006 SHALL have port: req_op  in  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
REQ-007 SHALL have port: req_addr  in  32  byte address.
REQ-008 SHALL have port: req_wdata  in  32  store data, right-justified for SB/SH.
REQ-009 SHALL have port: resp_valid  out  1  response present.
REQ-010 SHALL have port: resp_ready  in  1  consumer takes response.
REQ-011 SHALL have port: resp_rdata  out  32  extended load data; 0 for stores and faults.
REQ-012 SHALL have port: resp_misaligned  out  1  alignment fault flag.
REQ-013 SHALL have port: ram_address  out  RAM_AW  word index = req_addr[31:2], zero-extended or truncated to RAM_AW.
REQ-014 SHALL have port: ram_writedata  out  32  word written to RAM.
REQ-015 SHALL have port: ram_load  out  1  RAM write enable; RAM writes on rising clock edge when high.
REQ-016 SHALL have port: ram_out  in  32  RAM read data, combinational from ram_address.

Function
REQ-017 SHALL implement states IDLE, ACCESS, WRITE, RESP.
REQ-018 SHALL assert req_ready only in IDLE; acceptance = req_valid && req_ready at a rising edge.
REQ-019 SHALL register op, address, and wdata on acceptance; ram_address SHALL be driven from the registered address.
REQ-020 SHALL treat LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0, as misaligned: IDLE->RESP, resp_misaligned=1, resp_rdata=0, and ram_load never asserted.
REQ-021 SHALL treat aligned requests as IDLE->ACCESS.
REQ-022 SHALL use big-endian byte lanes: byte offset 0 = bits 31:24, offset 3 = bits 7:0; halfword offset 0 = bits 31:16, offset 2 = bits 15:0.
REQ-023 SHALL, on a load in ACCESS, capture the selected lane of ram_out, sign-extend (LB/LH) or zero-extend (LBU/LHU) it into resp_rdata, and go to RESP.
REQ-024 SHALL, on SW in ACCESS, assert ram_load=1 with ram_writedata=wdata for exactly one cycle, then go to RESP.
REQ-025 SHALL, on SB/SH in ACCESS, capture ram_out, replace the addressed lane with wdata[7:0] or wdata[15:0], hold the merged word in a register, and go to WRITE.
REQ-026 SHALL, in WRITE, assert ram_load=1 with ram_writedata = merged word for exactly one cycle, then go to RESP.
REQ-027 SHALL assert ram_load only in ACCESS(SW) or WRITE; ram_load SHALL be decoded combinationally from state.
REQ-028 SHALL hold resp_valid=1 in RESP, with resp_rdata and resp_misaligned stable, until resp_ready=1 at an edge; then go to IDLE.
REQ-029 SHALL meet this latency, with E0 = acceptance edge: resp_valid high after E0 (misaligned), after E1 (loads, SW), after E2 (SB, SH).
REQ-030 SHALL NOT accept a request in RESP even when resp_ready=1; back-to-back throughput is one request per (latency+1) cycles.
REQ-031 SHALL treat req_op and req_addr as don't-care when req_valid=0.

Reset
REQ-032 SHALL, while reset_n=0, force state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_misaligned=0, ram_address=0, ram_writedata=0, and ram_load=0, asynchronously.
REQ-033 SHALL abort any in-flight request on reset (including during WRITE), so no RAM write occurs at any edge while reset_n=0, and no response is produced for the aborted request.
REQ-034 SHALL accept requests from the first rising edge after reset_n deasserts.

Verification
REQ-035 SHALL verify: RAM word 4 = 0x8899AABB; LB 0x11 -> rdata 0xFFFFFF99; LBU 0x11 -> 0x00000099; LHU 0x12 -> 0x0000AABB; each resp_valid after E1, ram_load never high.
REQ-036 SHALL verify: SH 0x12, wdata 0x00001234 -> ram_load high in WRITE only, ram_writedata 0x88991234; later LW 0x10 -> 0x88991234.
REQ-037 SHALL verify: SW 0x10, wdata 0xDEADBEEF -> ram_load high one cycle in ACCESS, ram_address=4; resp after E1 with rdata 0.
REQ-038 SHALL verify: LW 0x13 and SH 0x11 -> resp_misaligned=1, rdata 0, resp after E0, RAM unchanged.
REQ-039 SHALL verify: SB 0x10 with reset_n pulsed low during WRITE -> ram_load drops immediately, word 4 unchanged, no resp_valid, req_ready=1.
REQ-040 SHALL verify: resp_ready held 0 for 5 cycles -> resp_valid and data stable, req_ready=0, and a new req_valid is ignored until the handshake completes.
